// File: rtl/shift_pkg.sv
// Shared mode encodings and the shift-class predicate for the universal shift register.
`default_nettype none

package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  function automatic logic is_shift(input logic [2:0] mode);
    logic shift_class;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: shift_class = 1'b1;
      default:                                          shift_class = 1'b0;
    endcase
    return shift_class;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_word_counter.sv
// Counts shift operations and pulses word_done on the edge that completes WIDTH of them.
// Revision: 1.0
`default_nettype none

module shift_word_counter #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic             restart,
  input  logic             sclr,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      // word_done is a single-cycle pulse: low unless this edge wraps the count
      word_done <= 1'b0;
      if (sclr || restart) begin
        cnt <= '0;
      end else if (step) begin
        if (cnt == LAST) begin
          cnt       <= '0;
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: shifts, rotates, load, sync clear/preset, word counter.
// Revision: 1.0
`default_nettype none

module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter int               CNT_W     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             preset,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] q_next;
  logic             step;
  logic             restart;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: q_next = d;
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

  // qnot is registered alongside q rather than derived, so both change on the same edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q    <= RESET_VAL;
      qnot <= ~RESET_VAL;
    end else if (preset) begin
      q    <= '1;
      qnot <= '0;
    end else if (en) begin
      q    <= q_next;
      qnot <= ~q_next;
    end
  end

  assign sout_l  = q[WIDTH-1];
  assign sout_r  = q[0];

  assign step    = en & is_shift(mode);
  assign restart = en & ((mode == MODE_LOAD) | (mode == MODE_CLR));

  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .clear     (clear),
    .step      (step),
    .restart   (restart),
    .sclr      (preset),
    .cnt       (cnt),
    .word_done (word_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios then randomized traffic vs. an arithmetic model.
`default_nettype none

module tb_universal_shift_reg;
  import shift_pkg::*;

  localparam int WIDTH = 6;
  localparam int CNT_W = 3;
  localparam int MAXV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             clear;
  logic             en;
  logic             preset;
  logic [2:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic             sout_l;
  logic             sout_r;
  logic [CNT_W-1:0] cnt;
  logic             word_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: register value as an integer, shifts since last restart, last pulse
  int m_q;
  int m_shifts;
  int m_done;

  universal_shift_reg #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .en        (en),
    .preset    (preset),
    .mode      (mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .d         (d),
    .q         (q),
    .qnot      (qnot),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .cnt       (cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},      int'(q),         m_q);
    check({tag, ".qnot"},   int'(qnot),      (MAXV - 1) - m_q);
    check({tag, ".cnt"},    int'(cnt),       m_shifts % WIDTH);
    check({tag, ".done"},   int'(word_done), m_done);
    check({tag, ".sout"},   int'({sout_l, sout_r}),
          ((m_q / (MAXV / 2)) % 2) * 2 + (m_q % 2));
  endtask

  task automatic model_reset();
    m_q      = 0;
    m_shifts = 0;
    m_done   = 0;
  endtask

  // Next register value computed arithmetically from the mode rules
  function automatic int model_next(input int cur, input int md, input int sl, input int sr, input int dv);
    int half = MAXV / 2;
    case (md)
      1:       return (cur * 2 + sl) % MAXV;
      2:       return cur / 2 + sr * half;
      3:       return (cur * 2) % MAXV + cur / half;
      4:       return cur / 2 + (cur % 2) * half;
      5:       return dv;
      6:       return cur / 2 + ((cur >= half) ? half : 0);
      7:       return 0;
      default: return cur;
    endcase
  endfunction

  task automatic cyc(input string tag, input bit p_en, input bit p_pre, input logic [2:0] p_mode,
                     input bit p_sl, input bit p_sr, input logic [WIDTH-1:0] p_d);
    int md;
    en     = p_en;
    preset = p_pre;
    mode   = p_mode;
    sin_l  = p_sl;
    sin_r  = p_sr;
    d      = p_d;
    @(posedge clk);
    #1;
    md = int'(p_mode);
    m_done = 0;
    if (p_pre) begin
      m_q      = MAXV - 1;
      m_shifts = 0;
    end else if (p_en) begin
      m_q = model_next(m_q, md, int'(p_sl), int'(p_sr), int'(p_d));
      if (md inside {1, 2, 3, 4, 6}) begin
        m_shifts = m_shifts + 1;
        if (m_shifts % WIDTH == 0) m_done = 1;
      end else if (md == 5 || md == 7) begin
        m_shifts = 0;
      end
    end
    check_all(tag);
  endtask

  // Asynchronous clear pulsed between edges; outputs must react before the next edge
  task automatic mid_clear(input string tag);
    #1 clear = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 clear = 1'b0;
  endtask

  initial begin
    clear  = 1'b1;
    en     = 1'b0;
    preset = 1'b0;
    mode   = MODE_HOLD;
    sin_l  = 1'b0;
    sin_r  = 1'b0;
    d      = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < WIDTH; i++) cyc("shl_ones", 1, 0, MODE_SHL, 1, 0, '0);
    check("shl_full", int'(q), 63);

    cyc("load_ror", 1, 0, MODE_LOAD, 0, 0, 6'b101100);
    for (int i = 0; i < WIDTH; i++) cyc("ror", 1, 0, MODE_ROR, 0, 0, '0);
    check("ror_restore", int'(q), int'(6'b101100));

    cyc("load_asr", 1, 0, MODE_LOAD, 0, 0, 6'b100110);
    cyc("asr1", 1, 0, MODE_ASR, 0, 0, '0);
    cyc("asr2", 1, 0, MODE_ASR, 0, 0, '0);
    check("asr_val", int'(q), int'(6'b111001));
    cyc("load_shr", 1, 0, MODE_LOAD, 0, 0, 6'b100110);
    cyc("shr1", 1, 0, MODE_SHR, 0, 0, '0);
    cyc("shr2", 1, 0, MODE_SHR, 0, 0, '0);
    check("shr_val", int'(q), int'(6'b001001));

    cyc("pre_shift", 1, 0, MODE_SHL, 1, 0, '0);
    for (int i = 0; i < 4; i++) cyc("en_off", 0, 0, MODE_SHL, 1, 0, '0);
    cyc("preset_en0", 0, 1, MODE_SHL, 0, 0, '0);

    for (int i = 0; i < 3; i++) cyc("pre_clear", 1, 0, MODE_SHL, 0, 0, '0);
    mid_clear("mid_clear");
    for (int i = 0; i < WIDTH; i++) cyc("post_clear", 1, 0, MODE_SHL, 1, 0, '0);

    for (int i = 0; i < 4; i++) cyc("shift4", 1, 0, MODE_ROL, 0, 0, '0);
    cyc("load_zero", 1, 0, MODE_LOAD, 0, 0, '0);
    for (int i = 0; i < WIDTH; i++) cyc("shl_after_load", 1, 0, MODE_SHL, i[0], 0, '0);
    check("wrap_after_load", int'(word_done), 1);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(7, 0) != 0), ($urandom_range(31, 0) == 0),
          3'($urandom_range(7, 0)), 1'($urandom), 1'($urandom), WIDTH'($urandom));
      if ($urandom_range(49, 0) == 0) mid_clear("rand_clear");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 6-stage left-shift DFF chain. All stages are built in one clocked register of WIDTH bits. It supports hold, logical and arithmetic shifts, rotates, parallel load and synchronous clear/preset, selected by a 3-bit mode. A shift counter produces a one-cycle pulse each time WIDTH shift/rotate operations have completed, so the block can act as a serializer/deserializer front end.

Parameters:
WIDTH, 6, register width in bits (>= 2)
CNT_W, 3, counter width; must satisfy 2^CNT_W > WIDTH-1
RESET_VAL, 0, value loaded into q on clear

Ports:
clk  input  1  clock, rising-edge active
clear  input  1  asynchronous active-high reset
en  input  1  clock enable; when 0, all state holds
preset  input  1  synchronous set-all-ones
mode  input  3  operation select (see Behaviour)
sin_l  input  1  serial in, enters at LSB on left shift
sin_r  input  1  serial in, enters at MSB on right shift
d  input  WIDTH  parallel load data
q  output  WIDTH  register contents
qnot  output  WIDTH  bitwise complement of q, registered
sout_l  output  1  q[WIDTH-1], combinational
sout_r  output  1  q[0], combinational
cnt  output  CNT_W  shift operations since last load/clear
word_done  output  1  one-cycle pulse when the WIDTH-th shift completes

Behaviour:
- One clock (clk), one asynchronous active-high reset (clear).
- clear asserted, at any time: q=RESET_VAL, qnot=~RESET_VAL, cnt=0, word_done=0. Takes effect immediately and holds while asserted. An operation in progress is discarded.
- Priority on each rising clk edge with clear=0: preset > en=0 > mode.
- preset=1, regardless of en: q=all ones, qnot=0, cnt=0, word_done=0.
- en=0: all registers hold. word_done is forced to 0.
- mode encoding (en=1):
  - 000 hold
  - 001 SHL: q <= {q[W-2:0], sin_l}
  - 010 SHR: q <= {sin_r, q[W-1:1]}
  - 011 ROL: q <= {q[W-2:0], q[W-1]}
  - 100 ROR: q <= {q[0], q[W-1:1]}
  - 101 LOAD: q <= d
  - 110 ASR: q <= {q[W-1], q[W-1:1]}
  - 111 CLR: q <= 0 (synchronous)
- qnot is always updated in the same edge as ~(next q). It is never combinational.
- Shift class means modes 001, 010, 011, 100 and 110.
- Counter:
  - A shift-class edge increments cnt.
  - When cnt==WIDTH-1 and a shift-class edge occurs: cnt <= 0 and word_done <= 1 for exactly one cycle.
  - Modes 101 and 111 set cnt <= 0.
  - Mode 000 holds cnt.
  - word_done is 0 on every edge that is not a wrapping shift.
- Latency: one clock from a mode sample to the q update. sout_l and sout_r follow q with zero delay.
- Back-to-back wraps are allowed: continuous shifting pulses word_done every WIDTH cycles.
- Mode changes mid-word do not reset cnt, unless the new mode is LOAD or CLR.
- clear deasserting coincident with a clk edge: that edge is ignored. The first operation is taken on the following edge.

Decomposition:
- Shared package shift_pkg holds:
  - mode localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_ASR, MODE_CLR
  - is_shift function returning the shift-class predicate
- One sub-module, shift_word_counter, holds cnt/word_done with inputs step, restart and sclr.
- The data path stays in the top module as a single case statement.

Test Plan:
- WIDTH=6. Pulse clear, then SHL with sin_l=1 for 6 edges -> q: 000001, 000011, 000111, 001111, 011111, 111111. word_done=1 only after the 6th edge, and cnt returns to 0.
- LOAD d=101100, then ROR for 6 edges -> q sequence 010110, 001011, 100101, 110010, 011001, 101100 (original restored). word_done pulses on the last edge.
- LOAD 100110, then ASR x2 -> 110011, then 111001. Next, LOAD 100110 and SHR with sin_r=0 x2 -> 010011, then 001001.
- Drive mode=SHL with en=0 for 4 edges -> q, qnot and cnt unchanged, word_done=0. Assert preset with en=0 -> q=111111, qnot=000000, cnt=0.
- Shift 3 times, then assert clear between edges -> q=000000 and qnot=111111 before the next edge. After release, SHL needs 6 more edges for word_done.
- Shift 4 times, then LOAD 000000 -> cnt=0. Then SHL 5 times -> no word_done. The 6th SHL -> word_done=1.
